// File: rtl/atomic_controller_pkg.sv
// Shared constants for the RV32A atomic sequencer: funct5 opcodes and FSM state encodings.
package atomic_controller_pkg;

    localparam logic [4:0] ATOMIC_ADD_OP  = 5'b00000;
    localparam logic [4:0] ATOMIC_SWAP_OP = 5'b00001;
    localparam logic [4:0] ATOMIC_LR_OP   = 5'b00010;
    localparam logic [4:0] ATOMIC_SC_OP   = 5'b00011;
    localparam logic [4:0] ATOMIC_XOR_OP  = 5'b00100;
    localparam logic [4:0] ATOMIC_OR_OP   = 5'b01000;
    localparam logic [4:0] ATOMIC_AND_OP  = 5'b01100;
    localparam logic [4:0] ATOMIC_MIN_OP  = 5'b10000;
    localparam logic [4:0] ATOMIC_MAX_OP  = 5'b10100;
    localparam logic [4:0] ATOMIC_MINU_OP = 5'b11000;
    localparam logic [4:0] ATOMIC_MAXU_OP = 5'b11100;
    // Not a legal AMO funct5; the decoder drives it when the instruction is not atomic.
    localparam logic [4:0] ATOMIC_NO_OP   = 5'b11111;

    typedef enum logic [1:0] {
        ATOMIC_STATE_IDLE  = 2'b00,
        ATOMIC_STATE_READ  = 2'b01,
        ATOMIC_STATE_WRITE = 2'b10,
        ATOMIC_STATE_DONE  = 2'b11
    } atomic_state_t;

    function automatic logic is_amo_op(input logic [4:0] op);
        case (op)
            ATOMIC_ADD_OP, ATOMIC_SWAP_OP, ATOMIC_XOR_OP, ATOMIC_OR_OP, ATOMIC_AND_OP,
            ATOMIC_MIN_OP, ATOMIC_MAX_OP, ATOMIC_MINU_OP, ATOMIC_MAXU_OP: is_amo_op = 1'b1;
            default:                                                     is_amo_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/atomic_controller_amo_alu.sv
// Combinational AMO datapath: new memory value from the old value and rs2. Ties keep old.
module amo_alu
    import atomic_controller_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] new_o
);

    logic rs2_lt_s;
    logic rs2_gt_s;
    logic rs2_lt_u;
    logic rs2_gt_u;

    assign rs2_lt_s = $signed(rs2_i) < $signed(old_i);
    assign rs2_gt_s = $signed(rs2_i) > $signed(old_i);
    assign rs2_lt_u = rs2_i < old_i;
    assign rs2_gt_u = rs2_i > old_i;

    always_comb begin
        new_o = old_i;
        case (op_i)
            ATOMIC_SWAP_OP: new_o = rs2_i;
            ATOMIC_ADD_OP:  new_o = old_i + rs2_i;
            ATOMIC_XOR_OP:  new_o = old_i ^ rs2_i;
            ATOMIC_AND_OP:  new_o = old_i & rs2_i;
            ATOMIC_OR_OP:   new_o = old_i | rs2_i;
            ATOMIC_MIN_OP:  new_o = rs2_lt_s ? rs2_i : old_i;
            ATOMIC_MAX_OP:  new_o = rs2_gt_s ? rs2_i : old_i;
            ATOMIC_MINU_OP: new_o = rs2_lt_u ? rs2_i : old_i;
            ATOMIC_MAXU_OP: new_o = rs2_gt_u ? rs2_i : old_i;
            default:        new_o = old_i;
        endcase
    end

endmodule

// File: rtl/atomic_controller.sv
// RV32A sequencer: runs LR/SC/AMO as read-modify-write on the data port and owns the reservation.
// States: IDLE wait for start | READ fetch old value | WRITE store result | DONE one-cycle result pulse
module atomic_controller
    import atomic_controller_pkg::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter int RESERVATION_GRANULE = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            atomic_op,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           rs2_value,
    input  logic                  store_snoop_valid,
    input  logic [ADDR_WIDTH-1:0] store_snoop_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rd_value,
    output logic                  misaligned
);

    atomic_state_t state_q, state_d;

    logic [4:0]                                op_q, op_d;
    logic [ADDR_WIDTH-1:2]                     addr_q, addr_d;
    logic [31:0]                               rs2_q, rs2_d;
    logic [31:0]                               wdata_q, wdata_d;
    logic [31:0]                               rd_q, rd_d;
    logic                                      mis_q, mis_d;
    logic                                      res_valid_q, res_valid_d;
    logic [ADDR_WIDTH-1:RESERVATION_GRANULE]   res_addr_q, res_addr_d;

    logic [31:0] amo_new;
    logic        snoop_hit;
    logic        start_res_hit;
    logic        unused_snoop_low;

    assign unused_snoop_low = ^store_snoop_addr[RESERVATION_GRANULE-1:0];

    assign snoop_hit     = store_snoop_valid && res_valid_q &&
                           (store_snoop_addr[ADDR_WIDTH-1:RESERVATION_GRANULE] == res_addr_q);
    assign start_res_hit = res_valid_q && (address[ADDR_WIDTH-1:RESERVATION_GRANULE] == res_addr_q);

    amo_alu u_amo_alu (
        .op_i  (op_q),
        .old_i (mem_rdata),
        .rs2_i (rs2_q),
        .new_o (amo_new)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ATOMIC_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q        <= '0;
            addr_q      <= '0;
            rs2_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            mis_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            mis_q       <= mis_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        mis_d   = mis_q;
        case (state_q)
            ATOMIC_STATE_IDLE: begin
                if (start && (atomic_op != ATOMIC_NO_OP)) begin
                    op_d   = atomic_op;
                    addr_d = address[ADDR_WIDTH-1:2];
                    rs2_d  = rs2_value;
                    mis_d  = 1'b0;
                    rd_d   = '0;
                    if (address[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = ATOMIC_STATE_DONE;
                    end else if (atomic_op == ATOMIC_SC_OP) begin
                        if (start_res_hit) begin
                            wdata_d = rs2_value;
                            state_d = ATOMIC_STATE_WRITE;
                        end else begin
                            rd_d    = 32'd1;
                            state_d = ATOMIC_STATE_DONE;
                        end
                    end else if ((atomic_op == ATOMIC_LR_OP) || is_amo_op(atomic_op)) begin
                        state_d = ATOMIC_STATE_READ;
                    end else begin
                        state_d = ATOMIC_STATE_DONE;
                    end
                end
            end
            ATOMIC_STATE_READ: begin
                if (mem_ready) begin
                    rd_d = mem_rdata;
                    if (op_q == ATOMIC_LR_OP) begin
                        state_d = ATOMIC_STATE_DONE;
                    end else begin
                        wdata_d = amo_new;
                        state_d = ATOMIC_STATE_WRITE;
                    end
                end
            end
            ATOMIC_STATE_WRITE: begin
                if (mem_ready) begin
                    if (op_q == ATOMIC_SC_OP) begin
                        rd_d = '0;
                    end
                    state_d = ATOMIC_STATE_DONE;
                end
            end
            ATOMIC_STATE_DONE: state_d = ATOMIC_STATE_IDLE;
            default:           state_d = ATOMIC_STATE_IDLE;
        endcase
    end

    // LR setting the reservation is applied last so it wins over a same-cycle snoop clear.
    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        if (snoop_hit) begin
            res_valid_d = 1'b0;
        end
        if ((state_q == ATOMIC_STATE_WRITE) && mem_ready && (op_q != ATOMIC_SC_OP) &&
            (addr_q[ADDR_WIDTH-1:RESERVATION_GRANULE] == res_addr_q)) begin
            res_valid_d = 1'b0;
        end
        if ((state_q == ATOMIC_STATE_DONE) && (op_q == ATOMIC_SC_OP) && !mis_q) begin
            res_valid_d = 1'b0;
        end
        if ((state_q == ATOMIC_STATE_READ) && mem_ready && (op_q == ATOMIC_LR_OP)) begin
            res_valid_d = 1'b1;
            res_addr_d  = addr_q[ADDR_WIDTH-1:RESERVATION_GRANULE];
        end
    end

    assign mem_req    = (state_q == ATOMIC_STATE_READ) || (state_q == ATOMIC_STATE_WRITE);
    assign mem_we     = (state_q == ATOMIC_STATE_WRITE);
    assign mem_addr   = {addr_q, 2'b00};
    assign mem_wdata  = wdata_q;
    assign busy       = mem_req;
    assign done       = (state_q == ATOMIC_STATE_DONE);
    assign rd_value   = rd_q;
    assign misaligned = (state_q == ATOMIC_STATE_DONE) && mis_q;

endmodule
